// File: rtl/llsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : llsc_pkg
// Purpose  : Shared types and helpers for the LL/SC reservation controller.
//            - llsc_state_e : controller state encoding
//            - GRAN_LSB_DEF : default reservation granule (16 bytes)
//            - gran_match   : address compare ignoring the low granule bits
// Optional : LLSC_TIMEOUT_EN (used by llsc_resv_ctrl, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package llsc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESV    = 2'd1,
    SC_PEND = 2'd2
  } llsc_state_e;

  localparam int unsigned GRAN_LSB_DEF = 4;

  // Callers cast both addresses up to 64 bits so one helper serves any
  // ADDR_W up to 64.
  function automatic logic gran_match(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input int unsigned lsb);
    return ((a ^ b) >> lsb) == 64'd0;
  endfunction

endpackage : llsc_pkg
`default_nettype wire

// File: rtl/llsc_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module   : llsc_tmo_cnt
// Purpose  : Reservation lifetime counter. Cleared when an LL is accepted,
//            counts every cycle the reservation is held, and flags the cycle
//            in which the count is about to reach all-ones so the controller
//            can drop the reservation at that edge.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clr_i         - LL accepted this cycle (restart count)
//            en_i          - reservation held this cycle
//            tmo_o         - reservation expires at the next edge
// Optional : instantiated only when LLSC_TIMEOUT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module llsc_tmo_cnt #(
  parameter int unsigned TMO_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tmo_o
);

  // All-ones minus one: the count seen in the last cycle before expiry.
  localparam logic [TMO_W-1:0] CNT_LAST = ~(TMO_W)'(1);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_o = en_i && (cnt_q == CNT_LAST);

endmodule : llsc_tmo_cnt
`default_nettype wire

// File: rtl/llsc_resv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : llsc_resv_ctrl
// Purpose  : LL/SC reservation controller for the MEM stage. Holds the
//            reserved granule, decides SC success, gates the SC store onto
//            the bus, drives the LLbit write port and breaks the reservation
//            on flush/ERET, matching external writes and (optionally) timeout.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            flush_i, eret_i          - pipeline flush / ERET commit
//            mem_ll_i, mem_sc_i       - LL / SC valid in MEM
//            mem_addr_i, mem_stall_i  - LL/SC address, MEM held by bus
//            snoop_we_i, snoop_addr_i - external master write
//            sc_store_en_o            - SC store may issue
//            sc_result_o              - SC result to rt (1 = success)
//            llbit_we_o, llbit_wdata_o- LLbit register write port
//            resv_valid_o, resv_addr_o- reservation state (granule aligned)
// Optional : define LLSC_TIMEOUT_EN to add the TMO_W-bit reservation timeout
// Revision : 1.0 - initial release
// ============================================================================
module llsc_resv_ctrl
  import llsc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GRAN_LSB = GRAN_LSB_DEF,
  parameter int unsigned TMO_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              eret_i,
  input  logic              mem_ll_i,
  input  logic              mem_sc_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              mem_stall_i,
  input  logic              snoop_we_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              sc_store_en_o,
  output logic              sc_result_o,
  output logic              llbit_we_o,
  output logic              llbit_wdata_o,
  output logic              resv_valid_o,
  output logic [ADDR_W-1:0] resv_addr_o
);

  localparam logic [ADDR_W-1:0] GRAN_MASK = {ADDR_W{1'b1}} << GRAN_LSB;

  llsc_state_e       state_q, state_d;
  logic [ADDR_W-1:0] resv_addr_q, resv_addr_d;
  logic              sc_dec_q, sc_dec_d;

  logic w_kill;
  logic w_sc;
  logic w_ll;
  logic w_in_resv;
  logic w_snoop_hit;
  logic w_sc_dec;
  logic w_ll_take;
  logic w_tmo_hit;

  assign w_kill    = flush_i | eret_i;
  // LL and SC together is illegal; the SC wins.
  assign w_sc      = mem_sc_i;
  assign w_ll      = mem_ll_i & ~mem_sc_i;
  assign w_in_resv = (state_q == RESV);

  assign w_snoop_hit = w_in_resv & snoop_we_i &
                       gran_match(64'(snoop_addr_i), 64'(resv_addr_q), GRAN_LSB);
  assign w_sc_dec    = w_in_resv & ~w_snoop_hit &
                       gran_match(64'(mem_addr_i), 64'(resv_addr_q), GRAN_LSB);

`ifdef LLSC_TIMEOUT_EN
  llsc_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_ll_take),
    .en_i  (w_in_resv),
    .tmo_o (w_tmo_hit)
  );
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    resv_addr_d   = resv_addr_q;
    sc_dec_d      = sc_dec_q;
    sc_store_en_o = 1'b0;
    sc_result_o   = 1'b0;
    llbit_we_o    = 1'b0;
    llbit_wdata_o = 1'b0;
    w_ll_take     = 1'b0;

    case (state_q)
      SC_PEND: begin
        if (w_kill) begin
          // Abort the held SC; its store never reaches the bus.
          state_d    = IDLE;
          llbit_we_o = 1'b1;
        end else begin
          // The store already owns bus order, so snoops cannot revoke it.
          sc_store_en_o = sc_dec_q;
          sc_result_o   = sc_dec_q;
          if (!mem_stall_i) begin
            state_d    = IDLE;
            llbit_we_o = 1'b1;
          end
        end
      end

      default: begin
        if (w_kill) begin
          state_d    = IDLE;
          llbit_we_o = w_in_resv;
        end else if (w_sc) begin
          sc_store_en_o = w_sc_dec;
          sc_result_o   = w_sc_dec;
          if (mem_stall_i) begin
            // LLbit is cleared once, when the stalled SC finally retires.
            state_d  = SC_PEND;
            sc_dec_d = w_sc_dec;
          end else begin
            state_d    = IDLE;
            llbit_we_o = 1'b1;
          end
        end else if (w_ll && !mem_stall_i) begin
          // An LL beats a same-cycle snoop: its read is ordered after it.
          state_d       = RESV;
          resv_addr_d   = mem_addr_i & GRAN_MASK;
          llbit_we_o    = 1'b1;
          llbit_wdata_o = 1'b1;
          w_ll_take     = 1'b1;
        end else if (w_snoop_hit || w_tmo_hit) begin
          state_d    = IDLE;
          llbit_we_o = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      resv_addr_q <= '0;
      sc_dec_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      resv_addr_q <= resv_addr_d;
      sc_dec_q    <= sc_dec_d;
    end
  end

  assign resv_valid_o = w_in_resv;
  assign resv_addr_o  = resv_addr_q;

  a_ll_sc_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem_ll_i && mem_sc_i));

  a_tmo_w_legal: assert property (@(posedge clk) TMO_W > 0);

endmodule : llsc_resv_ctrl
`default_nettype wire

// File: tb/tb_llsc_resv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_llsc_resv_ctrl
// Purpose  : Self-checking bench for llsc_resv_ctrl. A reference model of the
//            reservation rules predicts the outputs of every cycle and queues
//            them; a monitor compares the DUT against the queue.
// Optional : honours LLSC_TIMEOUT_EN (timeout expectations follow the macro)
// Revision : 1.0 - initial release
// ============================================================================
module tb_llsc_resv_ctrl;

  localparam int ADDR_W   = 32;
  localparam int GRAN_LSB = 4;
  localparam int TMO_W    = 4;
`ifdef LLSC_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i, eret_i, mem_ll_i, mem_sc_i, mem_stall_i, snoop_we_i;
  logic [ADDR_W-1:0] mem_addr_i, snoop_addr_i;
  logic              sc_store_en_o, sc_result_o, llbit_we_o, llbit_wdata_o, resv_valid_o;
  logic [ADDR_W-1:0] resv_addr_o;

  llsc_resv_ctrl #(
    .ADDR_W   (ADDR_W),
    .GRAN_LSB (GRAN_LSB),
    .TMO_W    (TMO_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .eret_i        (eret_i),
    .mem_ll_i      (mem_ll_i),
    .mem_sc_i      (mem_sc_i),
    .mem_addr_i    (mem_addr_i),
    .mem_stall_i   (mem_stall_i),
    .snoop_we_i    (snoop_we_i),
    .snoop_addr_i  (snoop_addr_i),
    .sc_store_en_o (sc_store_en_o),
    .sc_result_o   (sc_result_o),
    .llbit_we_o    (llbit_we_o),
    .llbit_wdata_o (llbit_wdata_o),
    .resv_valid_o  (resv_valid_o),
    .resv_addr_o   (resv_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              st;
    logic              res;
    logic              we;
    logic              wd;
    logic              rv;
    logic [ADDR_W-1:0] ra;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Reference model: is a reservation held, on which granule, how old;
  // is an SC waiting on the bus and what was its verdict.
  bit                m_resv;
  logic [ADDR_W-1:0] m_gran;
  logic [ADDR_W-1:0] m_addr;
  int                m_age;
  bit                m_pend;
  bit                m_pend_ok;

  function automatic logic [ADDR_W-1:0] gran(input logic [ADDR_W-1:0] a);
    return a >> GRAN_LSB;
  endfunction

  task automatic cyc(input bit ll, input bit sc, input logic [ADDR_W-1:0] a,
                     input bit stall, input bit fl, input bit er,
                     input bit swe, input logic [ADDR_W-1:0] sa);
    exp_t e;
    bit   ok, snoop_match, tmo;
    @(posedge clk);
    #1;
    mem_ll_i = ll; mem_sc_i = sc; mem_addr_i = a; mem_stall_i = stall;
    flush_i = fl; eret_i = er; snoop_we_i = swe; snoop_addr_i = sa;

    e    = '0;
    e.rv = m_resv;
    e.ra = m_addr;
    snoop_match = swe && (gran(sa) == m_gran);
    if (m_pend) begin
      if (fl || er) begin
        e.we   = 1'b1;
        m_pend = 1'b0;
      end else begin
        e.st  = m_pend_ok;
        e.res = m_pend_ok;
        if (!stall) begin
          e.we   = 1'b1;
          m_pend = 1'b0;
        end
      end
    end else if (fl || er) begin
      e.we   = m_resv;
      m_resv = 1'b0;
    end else if (sc) begin
      ok     = m_resv && (gran(a) == m_gran) && !snoop_match;
      e.st   = ok;
      e.res  = ok;
      m_resv = 1'b0;
      if (stall) begin
        m_pend    = 1'b1;
        m_pend_ok = ok;
      end else begin
        e.we = 1'b1;
      end
    end else if (ll && !stall) begin
      e.we   = 1'b1;
      e.wd   = 1'b1;
      m_resv = 1'b1;
      m_gran = gran(a);
      m_addr = gran(a) << GRAN_LSB;
      m_age  = 0;
    end else if (m_resv) begin
      tmo = TMO_ON && (m_age + 1 == (1 << TMO_W) - 1);
      if (snoop_match || tmo) begin
        e.we   = 1'b1;
        m_resv = 1'b0;
      end else begin
        m_age++;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_ll(input logic [ADDR_W-1:0] a);
    cyc(1, 0, a, 0, 0, 0, 0, '0);
  endtask

  task automatic do_sc(input logic [ADDR_W-1:0] a);
    cyc(0, 1, a, 0, 0, 0, 0, '0);
  endtask

  // Monitor: every cycle with a queued prediction is compared mid-cycle.
  always @(negedge clk) begin
    exp_t e, got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = '{sc_store_en_o, sc_result_o, llbit_we_o, llbit_wdata_o,
              resv_valid_o, resv_addr_o};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cycle%0d outputs: got st=%b res=%b we=%b wd=%b rv=%b ra=%h want st=%b res=%b we=%b wd=%b rv=%b ra=%h",
                 ncyc, got.st, got.res, got.we, got.wd, got.rv, got.ra,
                 e.st, e.res, e.we, e.wd, e.rv, e.ra);
      end
      ncyc++;
    end
  end

  initial begin
    logic [ADDR_W-1:0] ra, rs;
    int r;
    bit ll, sc;

    rst = 1'b1;
    flush_i = 0; eret_i = 0; mem_ll_i = 0; mem_sc_i = 0; mem_stall_i = 0;
    snoop_we_i = 0; mem_addr_i = '0; snoop_addr_i = '0;
    m_resv = 0; m_gran = '0; m_addr = '0; m_age = 0; m_pend = 0; m_pend_ok = 0;

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (resv_valid_o !== 1'b0 || resv_addr_o !== '0 || llbit_we_o !== 1'b0 ||
        sc_store_en_o !== 1'b0 || sc_result_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rv=%b ra=%h we=%b st=%b res=%b want all zero",
               resv_valid_o, resv_addr_o, llbit_we_o, sc_store_en_o, sc_result_o);
    end
    rst = 1'b0;

    // LL sets the reservation on the 16-byte granule.
    do_ll(32'h1000_0004);
    idle(1);
    // Matching SC two cycles after LL succeeds.
    do_sc(32'h1000_000C);
    idle(1);
    // Snoop to the same granule breaks it; SC fails.
    do_ll(32'h1000_0004);
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h1000_0008);
    do_sc(32'h1000_0004);
    // Snoop to a different granule is harmless.
    do_ll(32'h1000_0004);
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h1000_0010);
    do_sc(32'h1000_0000);
    // Stalled SC holds its verdict through a matching snoop.
    do_ll(32'h1000_0004);
    cyc(0, 1, 32'h1000_0004, 1, 0, 0, 0, '0);
    cyc(0, 1, 32'h1000_0004, 1, 0, 0, 1, 32'h1000_0000);
    cyc(0, 1, 32'h1000_0004, 1, 0, 0, 0, '0);
    cyc(0, 1, 32'h1000_0004, 1, 0, 0, 0, '0);
    cyc(0, 1, 32'h1000_0004, 0, 0, 0, 0, '0);
    idle(1);
    // Flush in the SC cycle, then ERET between LL and SC.
    do_ll(32'h1000_0004);
    cyc(0, 1, 32'h1000_0004, 0, 1, 0, 0, '0);
    idle(1);
    do_ll(32'h1000_0004);
    cyc(0, 0, '0, 0, 0, 1, 0, '0);
    do_sc(32'h1000_0004);
    // LL beats a same-cycle matching snoop.
    cyc(1, 0, 32'h2000_0040, 0, 0, 0, 1, 32'h2000_0044);
    do_sc(32'h2000_004C);
    // Stalled LL has no effect until the stall drops.
    cyc(1, 0, 32'h3000_0000, 1, 0, 0, 0, '0);
    cyc(1, 0, 32'h3000_0000, 0, 0, 0, 0, '0);
    // Flush while the SC is pending aborts it.
    cyc(0, 1, 32'h3000_0000, 1, 0, 0, 0, '0);
    cyc(0, 1, 32'h3000_0000, 1, 1, 0, 0, '0);
    idle(1);
    // Timeout: LL then 15 idle cycles, then SC.
    do_ll(32'h1000_0004);
    idle(15);
    do_sc(32'h1000_0004);
    idle(2);

    // Randomized traffic over a few neighbouring granules.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      ll = (r < 15);
      sc = (r >= 15) && (r < 27);
      ra = 32'h1000_0000 | ADDR_W'($urandom_range(0, 63));
      rs = 32'h1000_0000 | ADDR_W'($urandom_range(0, 63));
      cyc(ll, sc, ra, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, rs);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending predictions want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_llsc_resv_ctrl
`default_nettype wire
